// File: rtl/color_centroid_tracker.sv
// Colour-mask centroid tracker: per-frame count/row/col sums, then a serial divide.
// Define COLOR_TRACKER_BBOX_EN to add the bounding-box outputs.

module color_centroid_div_lane #(
    parameter int SUM_W = 28,
    parameter int CNT_W = 19,
    parameter int OUT_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [OUT_W-1:0] quot_nxt
);
    logic [SUM_W-1:0] num;
    logic [OUT_W-2:0] quot;
    logic [CNT_W-1:0] rem;
    logic [CNT_W:0]   rem_sh, rem_sub;
    logic             take;

    // Restoring step; only the low OUT_W quotient bits are kept since the
    // centroid can never exceed the frame width.
    always_comb begin
        rem_sh   = {rem, num[SUM_W-1]};
        rem_sub  = rem_sh - {1'b0, divisor};
        take     = (rem_sh >= {1'b0, divisor});
        quot_nxt = {quot, take};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num  <= '0;
            quot <= '0;
            rem  <= '0;
        end else if (load) begin
            num  <= dividend;
            quot <= '0;
            rem  <= '0;
        end else if (step) begin
            num  <= num << 1;
            quot <= quot_nxt[OUT_W-2:0];
            rem  <= CNT_W'(take ? rem_sub : rem_sh);
        end
    end
endmodule

module color_centroid_tracker #(
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int MIN_PIXELS = 16,
    parameter int DIV_CYCLES = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [12:0] row,
    input  logic [12:0] col,
    input  logic        i_color,
    output logic [12:0] centroid_row,
    output logic [12:0] centroid_col,
    output logic [18:0] pixel_count,
    output logic        obj_valid,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
`ifdef COLOR_TRACKER_BBOX_EN
    ,
    output logic [12:0] bbox_min_row,
    output logic [12:0] bbox_max_row,
    output logic [12:0] bbox_min_col,
    output logic [12:0] bbox_max_col
`endif
);
    localparam int CNT_W     = 19;
    localparam int SUM_W     = DIV_CYCLES;
    localparam int NUM_LANES = 2;
    localparam int IT_W      = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} d_state_t;
    d_state_t state, state_nxt;

    logic                              accept, hit, last_pix, eof;
    logic                              snap, valid_snap, last_iter;
    logic [CNT_W-1:0]                  cnt, cnt_add, div_d;
    logic [SUM_W-1:0]                  sum_r, sum_c, add_r, add_c;
    logic [IT_W-1:0]                   iter;
    logic [NUM_LANES-1:0][SUM_W-1:0]   lane_num;
    logic [NUM_LANES-1:0][12:0]        lane_q;

    assign accept     = pix_valid && (row < 13'(FRAME_H)) && (col < 13'(FRAME_W));
    assign hit        = accept && i_color;
    assign last_pix   = accept && (row == 13'(FRAME_H - 1)) && (col == 13'(FRAME_W - 1));
    assign cnt_add    = CNT_W'(hit);
    assign add_r      = hit ? SUM_W'(row) : '0;
    assign add_c      = hit ? SUM_W'(col) : '0;
    assign snap       = eof && (state == D_IDLE);
    assign valid_snap = (cnt >= CNT_W'(MIN_PIXELS));
    assign last_iter  = (state == D_RUN) && (iter == IT_W'(DIV_CYCLES - 1));

    // The pixel arriving alongside eof seeds the next frame instead of being lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            eof   <= 1'b0;
            cnt   <= '0;
            sum_r <= '0;
            sum_c <= '0;
        end else begin
            eof <= last_pix;
            if (eof) begin
                cnt   <= cnt_add;
                sum_r <= add_r;
                sum_c <= add_c;
            end else begin
                cnt   <= cnt + cnt_add;
                sum_r <= sum_r + add_r;
                sum_c <= sum_c + add_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= D_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            D_IDLE:  if (eof) state_nxt = valid_snap ? D_RUN : D_DONE;
            D_RUN:   if (last_iter) state_nxt = D_DONE;
            D_DONE:  state_nxt = D_IDLE;
            default: state_nxt = D_IDLE;
        endcase
    end

    assign busy         = (state == D_RUN);
    assign result_valid = (state == D_DONE);

    // Centroid lands on the edge entering D_DONE so it is visible with result_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            iter         <= '0;
            div_d        <= '0;
            pixel_count  <= '0;
            obj_valid    <= 1'b0;
            centroid_row <= '0;
            centroid_col <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun <= eof && (state != D_IDLE);
            if (snap) begin
                pixel_count <= cnt;
                div_d       <= cnt;
                iter        <= '0;
                if (!valid_snap) obj_valid <= 1'b0;
            end else if (state == D_RUN) begin
                iter <= iter + 1'b1;
            end
            if (last_iter) begin
                centroid_row <= lane_q[0];
                centroid_col <= lane_q[1];
                obj_valid    <= 1'b1;
            end
        end
    end

    assign lane_num[0] = sum_r;
    assign lane_num[1] = sum_c;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        color_centroid_div_lane #(
            .SUM_W(SUM_W),
            .CNT_W(CNT_W),
            .OUT_W(13)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (snap && valid_snap),
            .step     (state == D_RUN),
            .dividend (lane_num[g]),
            .divisor  (div_d),
            .quot_nxt (lane_q[g])
        );
    end

`ifdef COLOR_TRACKER_BBOX_EN
    logic [12:0] mn_r, mx_r, mn_c, mx_c;
    logic [12:0] sn_mn_r, sn_mx_r, sn_mn_c, sn_mx_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            mn_r         <= '1;
            mx_r         <= '0;
            mn_c         <= '1;
            mx_c         <= '0;
            sn_mn_r      <= '0;
            sn_mx_r      <= '0;
            sn_mn_c      <= '0;
            sn_mx_c      <= '0;
            bbox_min_row <= '0;
            bbox_max_row <= '0;
            bbox_min_col <= '0;
            bbox_max_col <= '0;
        end else begin
            if (eof) begin
                mn_r <= hit ? row : '1;
                mx_r <= hit ? row : '0;
                mn_c <= hit ? col : '1;
                mx_c <= hit ? col : '0;
            end else if (hit) begin
                if (row < mn_r) mn_r <= row;
                if (row > mx_r) mx_r <= row;
                if (col < mn_c) mn_c <= col;
                if (col > mx_c) mx_c <= col;
            end
            if (snap) begin
                sn_mn_r <= mn_r;
                sn_mx_r <= mx_r;
                sn_mn_c <= mn_c;
                sn_mx_c <= mx_c;
            end
            if (last_iter) begin
                bbox_min_row <= sn_mn_r;
                bbox_max_row <= sn_mx_r;
                bbox_min_col <= sn_mn_c;
                bbox_max_col <= sn_mx_c;
            end
        end
    end
`endif
endmodule
